// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: per-register pending-write counters that stall issue on RAW or counter saturation.
// Optional macro SCOREBOARD_BYPASS_EN lets a same-cycle writeback satisfy a source hazard (fwd_rs/fwd_rt).
module regfile_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic        issue_use_rs,
  input  logic        issue_use_rt,
  input  logic        issue_wen,
  input  logic [4:0]  issue_rd,
  input  logic        retire_valid,
  input  logic [4:0]  retire_rd,
  input  logic        kill_valid,
  input  logic [4:0]  kill_rd,
  output logic        issue_ack,
  output logic        stall,
  output logic [31:0] busy_mask,
  output logic        idle,
  output logic        err,
  output logic        fwd_rs,
  output logic        fwd_rt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_reg  [32];
  logic [CNT_W-1:0] cnt_next [32];
  logic [31:0]      uf_next;
  logic             err_reg;

  logic [CNT_W-1:0] cnt_rs;
  logic [CNT_W-1:0] cnt_rt;
  logic [CNT_W-1:0] cnt_rd;
  logic             raw_rs;
  logic             raw_rt;
  logic             haz_rs;
  logic             haz_rt;
  logic             sat;

  assign cnt_rs = cnt_reg[issue_rs];
  assign cnt_rt = cnt_reg[issue_rt];
  assign cnt_rd = cnt_reg[issue_rd];

  assign raw_rs = issue_use_rs & (issue_rs != 5'd0) & (cnt_rs != '0);
  assign raw_rt = issue_use_rt & (issue_rt != 5'd0) & (cnt_rt != '0);
  assign sat    = issue_wen & (issue_rd != 5'd0) & (cnt_rd == CNT_MAX);

`ifdef SCOREBOARD_BYPASS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic byp_rs;
  logic byp_rt;

  // The last outstanding writer is retiring now and is not being squashed: its data is on the writeback bus.
  assign byp_rs = (cnt_rs == CNT_ONE) & retire_valid & (retire_rd == issue_rs) &
                  ~(kill_valid & (kill_rd == issue_rs));
  assign byp_rt = (cnt_rt == CNT_ONE) & retire_valid & (retire_rd == issue_rt) &
                  ~(kill_valid & (kill_rd == issue_rt));
  assign haz_rs = raw_rs & ~byp_rs;
  assign haz_rt = raw_rt & ~byp_rt;
  assign fwd_rs = nRST & issue_valid & raw_rs & byp_rs;
  assign fwd_rt = nRST & issue_valid & raw_rt & byp_rt;
`else
  assign haz_rs = raw_rs;
  assign haz_rt = raw_rt;
  assign fwd_rs = 1'b0;
  assign fwd_rt = 1'b0;
`endif

  // Gated by nRST so both handshake outputs read 0 while reset is asserted.
  assign stall     = nRST & issue_valid & (haz_rs | haz_rt | sat);
  assign issue_ack = nRST & issue_valid & ~stall;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_cnt
      if (gi == 0) begin : g_r0
        assign cnt_next[gi]  = '0;
        assign uf_next[gi]   = 1'b0;
        assign busy_mask[gi] = 1'b0;
      end else begin : g_rn
        logic             inc;
        logic             ret;
        logic             kil;
        logic [CNT_W:0]   up;
        logic [CNT_W:0]   dn;

        assign inc = issue_ack & issue_wen & (issue_rd == 5'(gi));
        assign ret = retire_valid & (retire_rd == 5'(gi));
        assign kil = kill_valid & (kill_rd == 5'(gi));
        assign up  = {1'b0, cnt_reg[gi]} + (CNT_W+1)'(inc);
        assign dn  = (CNT_W+1)'(ret) + (CNT_W+1)'(kil);

        // Increment is applied before the decrements so issue+retire+kill nets correctly in one cycle.
        assign uf_next[gi]   = (up < dn);
        assign cnt_next[gi]  = (up < dn) ? '0 : CNT_W'(up - dn);
        assign busy_mask[gi] = (cnt_reg[gi] != '0);
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 32; i++) cnt_reg[i] <= '0;
      err_reg <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) cnt_reg[i] <= cnt_next[i];
      if (|uf_next) err_reg <= 1'b1;
    end
  end

  assign idle = ~|busy_mask;
  assign err  = err_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus randomized traffic against an array model.
module tb_regfile_scoreboard;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK;
  logic        nRST;
  logic        issue_valid;
  logic [4:0]  issue_rs;
  logic [4:0]  issue_rt;
  logic        issue_use_rs;
  logic        issue_use_rt;
  logic        issue_wen;
  logic [4:0]  issue_rd;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic        kill_valid;
  logic [4:0]  kill_rd;
  logic        issue_ack;
  logic        stall;
  logic [31:0] busy_mask;
  logic        idle;
  logic        err;
  logic        fwd_rs;
  logic        fwd_rt;

  int pass_cnt = 0;
  int total    = 0;

  // Reference model: pending writers per register and the sticky error.
  int m_cnt [32];
  bit m_err;

  regfile_scoreboard #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
    .issue_wen(issue_wen), .issue_rd(issue_rd),
    .retire_valid(retire_valid), .retire_rd(retire_rd),
    .kill_valid(kill_valid), .kill_rd(kill_rd),
    .issue_ack(issue_ack), .stall(stall), .busy_mask(busy_mask),
    .idle(idle), .err(err), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_err = 1'b0;
  endfunction

  function automatic bit m_bypass(logic [4:0] s);
    return BYP && m_cnt[s] == 1 && retire_valid && retire_rd == s && !(kill_valid && kill_rd == s);
  endfunction

  function automatic bit m_src_haz(logic use_s, logic [4:0] s);
    return use_s && s != 0 && m_cnt[s] != 0 && !m_bypass(s);
  endfunction

  function automatic bit m_stall();
    bit sat;
    sat = issue_wen && issue_rd != 0 && m_cnt[issue_rd] == MAXC;
    return issue_valid && (m_src_haz(issue_use_rs, issue_rs) || m_src_haz(issue_use_rt, issue_rt) || sat);
  endfunction

  function automatic bit m_ack();
    return issue_valid && !m_stall();
  endfunction

  function automatic bit m_fwd_rs();
    return issue_valid && issue_use_rs && issue_rs != 0 && m_cnt[issue_rs] != 0 && m_bypass(issue_rs);
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  function automatic void m_update();
    bit ack;
    int v;
    ack = m_ack();
    for (int n = 1; n < 32; n++) begin
      v = m_cnt[n];
      if (ack && issue_wen && issue_rd == n) v++;
      if (retire_valid && retire_rd == n) v--;
      if (kill_valid && kill_rd == n) v--;
      if (v < 0) begin
        v = 0;
        m_err = 1'b1;
      end
      m_cnt[n] = v;
    end
  endfunction

  task automatic clear_inputs();
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_use_rs = 0; issue_use_rt = 0;
    issue_wen = 0; issue_rd = 0; retire_valid = 0; retire_rd = 0; kill_valid = 0; kill_rd = 0;
  endtask

  task automatic set_issue(logic [4:0] rs, logic urs, logic [4:0] rt, logic urt, logic wen, logic [4:0] rd);
    issue_valid = 1; issue_rs = rs; issue_use_rs = urs; issue_rt = rt; issue_use_rt = urt;
    issue_wen = wen; issue_rd = rd;
  endtask

  // Advance one clock edge, updating the model with the inputs that were stable at that edge.
  task automatic tick();
    @(posedge CLK);
    m_update();
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    nRST = 0;
    m_reset();
    #2;
    total++; if (busy_mask !== 32'h0) $display("FAIL reset_busy: got %h want 00000000", busy_mask); else pass_cnt++;
    total++; if (idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", idle); else pass_cnt++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
    total++; if ({stall, issue_ack, fwd_rs, fwd_rt} !== 4'b0) $display("FAIL reset_hs: got %b want 0000", {stall, issue_ack, fwd_rs, fwd_rt}); else pass_cnt++;
    @(negedge CLK);
    nRST = 1;
    @(posedge CLK);
    #1;
    $display("reset released at %0t", $time);
  endtask

  task automatic test_basic_issue();
    set_issue(5'd1, 1, 5'd2, 1, 1, 5'd3);
    #1;
    total++; if (issue_ack !== 1'b1 || stall !== 1'b0) $display("FAIL basic_ack: got ack=%b stall=%b want ack=1 stall=0", issue_ack, stall); else pass_cnt++;
    tick();
    clear_inputs();
    #1;
    total++; if (busy_mask !== 32'h00000008) $display("FAIL basic_busy: got %h want 00000008", busy_mask); else pass_cnt++;
    total++; if (idle !== 1'b0) $display("FAIL basic_idle: got %b want 0", idle); else pass_cnt++;
    $display("basic issue rd=3: busy_mask=%h idle=%b", busy_mask, idle);
    retire_valid = 1; retire_rd = 5'd3;
    tick();
    clear_inputs();
  endtask

  task automatic test_raw_hazard();
    set_issue(5'd0, 0, 5'd0, 0, 1, 5'd3);
    tick();
    set_issue(5'd3, 1, 5'd0, 0, 0, 5'd0);
    #1;
    total++; if (stall !== 1'b1 || issue_ack !== 1'b0) $display("FAIL raw_stall: got stall=%b ack=%b want stall=1 ack=0", stall, issue_ack); else pass_cnt++;
    retire_valid = 1; retire_rd = 5'd3;
    #1;
    total++; if (stall !== !BYP || fwd_rs !== BYP) $display("FAIL raw_retire_cycle: got stall=%b fwd_rs=%b want stall=%b fwd_rs=%b", stall, fwd_rs, !BYP, BYP); else pass_cnt++;
    tick();
    retire_valid = 0;
    #1;
    total++; if (stall !== 1'b0 || issue_ack !== 1'b1) $display("FAIL raw_after_retire: got stall=%b ack=%b want stall=0 ack=1", stall, issue_ack); else pass_cnt++;
    $display("raw hazard on r3 resolved, stall=%b", stall);
    tick();
    clear_inputs();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      set_issue(5'd0, 0, 5'd0, 0, 1, 5'd5);
      #1;
      total++; if (issue_ack !== 1'b1) $display("FAIL sat_fill%0d: got ack=%b want 1", k, issue_ack); else pass_cnt++;
      tick();
    end
    #1;
    total++; if (stall !== 1'b1 || issue_ack !== 1'b0) $display("FAIL sat_stall: got stall=%b ack=%b want stall=1 ack=0", stall, issue_ack); else pass_cnt++;
    retire_valid = 1; retire_rd = 5'd5;
    tick();
    retire_valid = 0;
    #1;
    total++; if (issue_ack !== 1'b1) $display("FAIL sat_ack_after_retire: got ack=%b want 1", issue_ack); else pass_cnt++;
    $display("saturation on r5 released after one retire");
    tick();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      retire_valid = 1; retire_rd = 5'd5;
      tick();
    end
    clear_inputs();
    #1;
    total++; if (busy_mask[5] !== 1'b0) $display("FAIL sat_drain: got busy5=%b want 0", busy_mask[5]); else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    set_issue(5'd0, 0, 5'd0, 0, 1, 5'd7);
    tick();
    retire_valid = 1; retire_rd = 5'd7; kill_valid = 1; kill_rd = 5'd7;
    #1;
    total++; if (issue_ack !== 1'b1) $display("FAIL same_ack: got %b want 1", issue_ack); else pass_cnt++;
    tick();
    clear_inputs();
    #1;
    total++; if (busy_mask[7] !== 1'b0 || err !== 1'b0) $display("FAIL same_net: got busy7=%b err=%b want busy7=0 err=0", busy_mask[7], err); else pass_cnt++;
    $display("issue+retire+kill on r7: busy7=%b err=%b", busy_mask[7], err);
  endtask

  task automatic test_r0_underflow();
    for (int k = 0; k < 4; k++) begin
      set_issue(5'd0, 1, 5'd0, 1, 1, 5'd0);
      retire_valid = (k == 2); retire_rd = 5'd0; kill_valid = (k == 3); kill_rd = 5'd0;
      #1;
      total++; if (stall !== 1'b0) $display("FAIL r0_stall%0d: got %b want 0", k, stall); else pass_cnt++;
      tick();
    end
    clear_inputs();
    #1;
    total++; if (busy_mask[0] !== 1'b0 || err !== 1'b0) $display("FAIL r0_busy: got busy0=%b err=%b want 0 0", busy_mask[0], err); else pass_cnt++;
    retire_valid = 1; retire_rd = 5'd9;
    tick();
    clear_inputs();
    #1;
    total++; if (err !== 1'b1 || busy_mask[9] !== 1'b0) $display("FAIL underflow: got err=%b busy9=%b want err=1 busy9=0", err, busy_mask[9]); else pass_cnt++;
    tick(); tick();
    total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else pass_cnt++;
    $display("underflow on r9: err=%b", err);
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = total - pass_cnt;
    for (int c = 0; c < 400; c++) begin
      issue_valid  = ($urandom_range(0, 3) != 0);
      issue_rs     = 5'($urandom_range(0, 7));
      issue_rt     = 5'($urandom_range(0, 7));
      issue_use_rs = 1'($urandom_range(0, 1));
      issue_use_rt = 1'($urandom_range(0, 1));
      issue_wen    = 1'($urandom_range(0, 1));
      issue_rd     = 5'($urandom_range(0, 7));
      retire_valid = ($urandom_range(0, 1) == 0);
      retire_rd    = 5'($urandom_range(0, 7));
      kill_valid   = ($urandom_range(0, 5) == 0);
      kill_rd      = 5'($urandom_range(0, 7));
      #1;
      total++; if (stall !== m_stall() || issue_ack !== m_ack()) $display("FAIL rand_hs c=%0d: got stall=%b ack=%b want stall=%b ack=%b", c, stall, issue_ack, m_stall(), m_ack()); else pass_cnt++;
      total++; if (fwd_rs !== m_fwd_rs()) $display("FAIL rand_fwd c=%0d: got %b want %b", c, fwd_rs, m_fwd_rs()); else pass_cnt++;
      tick();
      total++; if (busy_mask !== m_busy() || idle !== (m_busy() == 32'h0) || err !== m_err) $display("FAIL rand_state c=%0d: got busy=%h idle=%b err=%b want busy=%h idle=%b err=%b", c, busy_mask, idle, err, m_busy(), m_busy() == 32'h0, m_err); else pass_cnt++;
    end
    clear_inputs();
    $display("random traffic: 400 cycles, %0d new failures", (total - pass_cnt) - errs_before);
  endtask

  task automatic test_async_reset();
    set_issue(5'd0, 0, 5'd0, 0, 1, 5'd4);
    retire_valid = 0; kill_valid = 0;
    for (int i = 1; i < 32; i++) begin
      // Drain everything except what this test builds, so only r4 stays busy.
      if (m_cnt[i] != 0) begin
        issue_valid = 0;
        retire_valid = 1; retire_rd = 5'(i);
        while (m_cnt[i] != 0) tick();
        retire_valid = 0;
      end
    end
    set_issue(5'd0, 0, 5'd0, 0, 1, 5'd4);
    tick(); tick();
    set_issue(5'd4, 1, 5'd0, 0, 0, 5'd0);
    #1;
    total++; if (stall !== 1'b1 || busy_mask !== 32'h00000010) $display("FAIL arst_pre: got stall=%b busy=%h want stall=1 busy=00000010", stall, busy_mask); else pass_cnt++;
    #1;
    nRST = 0;
    m_reset();
    #1;
    total++; if (busy_mask !== 32'h0 || idle !== 1'b1 || stall !== 1'b0 || err !== 1'b0 || issue_ack !== 1'b0) $display("FAIL arst_now: got busy=%h idle=%b stall=%b err=%b ack=%b want 0 1 0 0 0", busy_mask, idle, stall, err, issue_ack); else pass_cnt++;
    nRST = 1;
    #1;
    total++; if (issue_ack !== 1'b1) $display("FAIL arst_after: got ack=%b want 1", issue_ack); else pass_cnt++;
    $display("async reset mid-cycle: busy=%h idle=%b", busy_mask, idle);
    tick();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_raw_hazard();
    test_saturation();
    test_same_cycle();
    test_r0_underflow();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Tracks outstanding writes to the 32 x 32-bit CPU register file.
- Sits beside decode. It gates instruction issue (stall) until every source register it reads has no pending writeback.
- Keeps a per-register pending-write counter: incremented on issue, decremented on writeback retire or on squash (kill).
- Register 0 is never pending.

Parameters:
- CNT_W, 2: width of each per-register pending counter; maximum in-flight writers per register = 2^CNT_W - 1.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode presents an instruction.
- issue_rs  in  5  source register 1.
- issue_rt  in  5  source register 2.
- issue_use_rs  in  1  instruction reads rs.
- issue_use_rt  in  1  instruction reads rt.
- issue_wen  in  1  instruction writes a register.
- issue_rd  in  5  destination register.
- retire_valid  in  1  writeback is writing the register file this cycle.
- retire_rd  in  5  register being written.
- kill_valid  in  1  an in-flight writer is squashed.
- kill_rd  in  5  destination of the squashed writer.
- issue_ack  out  1  instruction accepted this cycle.
- stall  out  1  instruction held.
- busy_mask  out  32  bit n = 1 when counter[n] != 0.
- idle  out  1  all counters zero.
- err  out  1  sticky underflow error.
- fwd_rs  out  1  rs is satisfied by this cycle's writeback (feature only).
- fwd_rt  out  1  rt is satisfied by this cycle's writeback (feature only).

Behaviour:
- Reset (async, nRST=0): all counters = 0, err = 0. Outputs: busy_mask = 0, idle = 1, stall = 0, issue_ack = 0, fwd_rs = 0, fwd_rt = 0.
- Index 0 counter is held at 0. Issue, retire or kill targeting r0 is ignored; r0 never causes a hazard.
- Hazards are combinational on the current cycle's inputs and counters:
  - haz_rs = issue_use_rs & rs != 0 & cnt[rs] != 0.
  - haz_rt = issue_use_rt & rt != 0 & cnt[rt] != 0.
  - sat = issue_wen & rd != 0 & cnt[rd] == max.
- stall = issue_valid & (haz_rs | haz_rt | sat).
- issue_ack = issue_valid & ~stall.
- Both are 0 when issue_valid = 0.
- Counter update at the rising edge, per register n:
  - delta = +1 if (issue_ack & issue_wen & rd == n)
  - delta = delta - 1 if (retire_valid & retire_rd == n)
  - delta = delta - 1 if (kill_valid & kill_rd == n)
  - Issue, retire and kill on the same register in one cycle are summed, so the net delta is in the range -2..+1.
- Underflow: if the decrement exceeds the current count, the counter clamps at 0 and err sets. err clears only on reset.
- Retire and kill never stall and are always accepted.
- Latency: an issue with rd=n makes busy_mask[n] = 1 the following cycle.
- A retire makes a dependent instruction's stall drop the cycle after the retire, because the register file write is visible from the next cycle.
- busy_mask and idle are registered-state decodes, with no combinational path from the inputs.
- An instruction whose rd equals its own rs is checked against the pre-issue count only. It does not stall on itself.
- Reset mid-operation clears everything immediately. In-flight writers are then untracked, so the pipeline must also be flushed by reset.

Optional Feature:
- Macro SCOREBOARD_BYPASS_EN.
- Defined:
  - A source hazard on register s is suppressed when cnt[s] == 1, retire_valid = 1 and retire_rd == s, and no kill targets s this cycle.
  - The corresponding fwd_rs / fwd_rt asserts, and decode muxes the writeback data in.
  - Hazards then clear in the same cycle as the retire.
- Undefined: fwd_rs = fwd_rt = 0 constantly, and stalls drop the cycle after the retire.

Test Plan:
- Reset, then issue rs=1, rt=2, wen, rd=3 with all counters 0 -> issue_ack=1 that cycle; next cycle busy_mask=0x00000008, idle=0.
- Issue rd=3, then next cycle issue rs=3 (use_rs=1) with no retire -> stall=1, issue_ack=0. Retire rd=3 -> without the macro stall=0 the following cycle; with the macro stall=0 and fwd_rs=1 in the retire cycle.
- CNT_W=2: three issues to rd=5 with no retire, then a fourth issue wen rd=5 -> stall=1 (sat). After one retire rd=5 the fourth is acked next cycle.
- Same cycle: issue_ack with rd=7 (cnt 1), retire rd=7, kill rd=7 -> cnt[7]=0 next cycle, busy_mask[7]=0, err=0.
- Issue wen rd=0 and use_rs with rs=0 repeatedly -> never stall, busy_mask[0]=0. Retire rd=9 while cnt[9]=0 -> err=1 and stays set, cnt[9]=0.
- Pull nRST low with cnt[4]=2 and issue_valid high -> busy_mask=0, idle=1, stall=0 and err=0 immediately, without waiting for a clock edge.
